// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on both sides, registered occupancy count and threshold flags.
module sync_fifo #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Status decodes from registered pointers and count; no path from the
    // opposite handshake, so ready/valid never combinationally chain.
    always_comb begin
        full         = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        empty        = (wr_ptr == rd_ptr);
        in_ready     = !full;
        out_valid    = !empty;
        push         = in_valid && in_ready;
        pop          = out_valid && out_ready;
        out_data     = mem[rd_ptr[IDX_W-1:0]];
        almost_full  = (count >= CNT_W'(AFULL_THRESH));
        almost_empty = (count <= CNT_W'(AEMPTY_THRESH));
    end

    // Pointer and count update: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && push) begin
            mem[wr_ptr[IDX_W-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (default params).
module tb_sync_fifo;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        step();
        step();
        reset_n = 1'b1;

        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_afull", 32'(almost_full), 0);

        // Three pushes with consumer stalled
        in_valid = 1'b1;
        in_data  = 32'h11;
        step();
        chk("t1_ov_after_first", 32'(out_valid), 1);
        chk("t1_cnt_after_first", 32'(count), 1);
        in_data = 32'h22;
        step();
        in_data = 32'h33;
        step();
        in_valid = 1'b0;
        chk("t1_count", 32'(count), 3);
        chk("t1_out_data", out_data, 32'h11);
        chk("t1_empty", 32'(empty), 0);
        step();
        chk("t1_stall_stable", out_data, 32'h11);
        out_ready = 1'b1;
        chk("t1_pop0", out_data, 32'h11);
        step();
        chk("t1_pop1", out_data, 32'h22);
        step();
        chk("t1_pop2", out_data, 32'h33);
        step();
        out_ready = 1'b0;
        chk("t1_drained", 32'(empty), 1);

        // Fill to full with threshold checks along the way
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_count", 32'(count), 32'(i));
            chk("t2_aempty", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
            chk("t2_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            in_data = 32'(i);
            step();
        end
        chk("t2_full", 32'(full), 1);
        chk("t2_in_ready", 32'(in_ready), 0);
        chk("t2_count8", 32'(count), 8);
        chk("t2_afull8", 32'(almost_full), 1);
        in_data = 32'h99;
        step();
        chk("t2_no_overflow", 32'(count), 8);
        chk("t2_head", out_data, 0);
        // Pop while full with producer still offering: no same-cycle slot reuse
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_pop_from_full", 32'(count), 7);
        chk("t2_ready_after_pop", 32'(in_ready), 1);
        for (int i = 1; i < 8; i++) begin
            chk("t2_pop_data", out_data, 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("t2_empty", 32'(empty), 1);
        chk("t2_count0", 32'(count), 0);

        // Fill to 4, then streaming push/pop across pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'(100 + i);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 32'(104 + k);
            chk("t3_stream_data", out_data, 32'(100 + k));
            chk("t3_stream_count", 32'(count), 4);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_count_after", 32'(count), 4);
        chk("t3_head_after", out_data, 32'd120);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain", out_data, 32'(120 + i));
            step();
        end
        out_ready = 1'b0;
        chk("t3_empty", 32'(empty), 1);

        // Flush with push and pop active
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'(32'h50 + i);
            step();
        end
        chk("t5_count5", 32'(count), 5);
        flush     = 1'b1;
        in_data   = 32'hEE;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_out_valid", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data  = 32'h77;
        step();
        in_valid = 1'b0;
        chk("t5_post_count", 32'(count), 1);
        chk("t5_post_data", out_data, 32'h77);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_post_empty", 32'(empty), 1);

        // Reset mid-operation with a push presented
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'(32'h60 + i);
            step();
        end
        reset_n = 1'b0;
        in_data = 32'hCD;
        step();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        chk("t6_count", 32'(count), 0);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 32'hAB;
        step();
        in_valid = 1'b0;
        chk("t6_count1", 32'(count), 1);
        chk("t6_out_valid1", 32'(out_valid), 1);
        chk("t6_first_word", out_data, 32'hAB);
        step();
        chk("t6_hold", out_data, 32'hAB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
